// File: rtl/rv_pkg.sv
// Shared register-file definitions for the writeback path.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!found && req[j]) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among N_REQ writeback requesters with
// round-robin arbitration, one registered write per cycle, plus forwarding/hazard info.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int A_WIDTH = REG_ADDR_W,
  parameter int D_WIDTH = XLEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*A_WIDTH-1:0] req_addr,
  input  logic [N_REQ*D_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     WE3,
  output logic [A_WIDTH-1:0]       AD3,
  output logic [D_WIDTH-1:0]       WD3,
  output logic                     fwd_valid,
  output logic [A_WIDTH-1:0]       fwd_addr,
  output logic [D_WIDTH-1:0]       fwd_data,
  output logic [2**A_WIDTH-1:0]    pend_mask
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      gnt_idx;
  logic [N_REQ-1:0]   gnt;
  logic               arb_en;
  logic               xfer;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_data;

  // Gating with rst_n keeps ready low for the whole reset interval.
  assign arb_en = ~hold & rst_n;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign ptr_next  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*A_WIDTH +: A_WIDTH];
        sel_data = req_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_next;
    end
  end

  // x0 writes are still consumed, but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (xfer) begin
      WE3 <= (sel_addr != '0);
      AD3 <= sel_addr;
      WD3 <= sel_data;
    end else begin
      WE3 <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) pend_mask[req_addr[i*A_WIDTH +: A_WIDTH]] = 1'b1;
    end
    if (WE3) pend_mask[AD3] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign fwd_valid = WE3;
  assign fwd_addr  = AD3;
  assign fwd_data  = WD3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural arbiter/write-port model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            WE3;
  logic [AW-1:0]   AD3;
  logic [DW-1:0]   WD3;
  logic            fwd_valid;
  logic [AW-1:0]   fwd_addr;
  logic [DW-1:0]   fwd_data;
  logic [31:0]     pend_mask;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.N_REQ(N), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .WE3       (WE3),
    .AD3       (AD3),
    .WD3       (WD3),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .pend_mask (pend_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25)
        $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pointer, one-deep write stage, register file image.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] rf_dut [32];

  function automatic int modelGrant();
    int j;
    if (hold || !rst_n) return -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0;
      m_we  = 1'b0;
      m_ad  = '0;
      m_wd  = '0;
    end else begin
      g = modelGrant();
      if (g >= 0) begin
        m_ad  = req_addr[g*AW +: AW];
        m_wd  = req_data[g*DW +: DW];
        m_we  = (m_ad != 0);
        m_ptr = (g + 1) % N;
      end else begin
        m_we = 1'b0;
      end
    end
  end

  // Register file image fed by the DUT write port, used by the collision scenario.
  initial for (int r = 0; r < 32; r++) rf_dut[r] = '0;
  always @(posedge clk) if (rst_n && WE3) rf_dut[AD3] <= WD3;

  always @(negedge clk) begin
    int          g;
    logic [2:0]  er;
    logic [31:0] ep;
    g  = modelGrant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    ep = '0;
    for (int i = 0; i < N; i++)
      if (req_valid[i]) ep[req_addr[i*AW +: AW]] = 1'b1;
    if (m_we) ep[m_ad] = 1'b1;
    ep[0] = 1'b0;
    checkOutput("req_ready", 64'(req_ready), 64'(er));
    checkOutput("WE3",       64'(WE3),       64'(m_we));
    checkOutput("AD3",       64'(AD3),       64'(m_ad));
    checkOutput("WD3",       64'(WD3),       64'(m_wd));
    checkOutput("fwd_valid", 64'(fwd_valid), 64'(m_we));
    checkOutput("fwd_addr",  64'(fwd_addr),  64'(m_ad));
    checkOutput("fwd_data",  64'(fwd_data),  64'(m_wd));
    checkOutput("pend_mask", 64'(pend_mask), 64'(ep));
  end

  // Requester-rule assertions: a pending request may not drop or change before its transfer.
  logic [N-1:0]    prev_valid;
  logic [N-1:0]    prev_ready;
  logic [N*AW-1:0] prev_addr;
  logic [N*DW-1:0] prev_data;
  logic            rst_seen = 1'b1;

  always @(negedge rst_n) rst_seen = 1'b1;

  always @(negedge clk) begin
    if (rst_n && !rst_seen) begin
      for (int i = 0; i < N; i++) begin
        if (prev_valid[i] && !prev_ready[i]) begin
          assert (req_valid[i] &&
                  req_addr[i*AW +: AW] == prev_addr[i*AW +: AW] &&
                  req_data[i*DW +: DW] == prev_data[i*DW +: DW])
          else $error("[TB] requester %0d broke the valid/stable rule", i);
        end
      end
    end
    prev_valid = req_valid;
    prev_ready = req_ready;
    prev_addr  = req_addr;
    prev_data  = req_data;
    rst_seen   = !rst_n;
  end

  task automatic applyStimulus(input logic [2:0] v,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic h);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    hold      = h;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    hold      = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] xfer;
    rst_n     = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_WE3", 64'(WE3), 64'd0);
    checkOutput("rst_AD3", 64'(AD3), 64'd0);
    checkOutput("rst_WD3", 64'(WD3), 64'd0);
    checkOutput("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    #1 rst_n = 1'b1;

    // Single write: accepted this cycle, written next cycle.
    applyStimulus(3'b001, 5'd10, 5'd0, 5'd0, 32'hDEADBEEF, 0, 0, 1'b0);
    checkOutput("t1_ready", 64'(req_ready), 64'h1);
    checkOutput("t1_pend_req", 64'(pend_mask[10]), 64'd1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("t1_WE3", 64'(WE3), 64'd1);
    checkOutput("t1_AD3", 64'(AD3), 64'd10);
    checkOutput("t1_WD3", 64'(WD3), 64'hDEADBEEF);
    checkOutput("t1_fwd_valid", 64'(fwd_valid), 64'd1);
    checkOutput("t1_pend_inflight", 64'(pend_mask[10]), 64'd1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("t1_WE3_after", 64'(WE3), 64'd0);

    // Fairness with all three continuously valid.
    doReset();
    for (int c = 0; c < 9; c++) begin
      applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 32'h300, 1'b0);
      checkOutput("t2_ready", 64'(req_ready), 64'(1 << (c % 3)));
      if (c > 0) begin
        checkOutput("t2_WE3", 64'(WE3), 64'd1);
        checkOutput("t2_AD3", 64'(AD3), 64'(((c - 1) % 3) + 1));
      end
    end

    // x0 write is consumed but never written; pointer moves to 2.
    doReset();
    applyStimulus(3'b010, 0, 5'd0, 0, 0, 32'h1234, 0, 1'b0);
    checkOutput("t3_ready", 64'(req_ready), 64'h2);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("t3_WE3", 64'(WE3), 64'd0);
    checkOutput("t3_fwd_valid", 64'(fwd_valid), 64'd0);
    applyStimulus(3'b110, 0, 5'd9, 5'd11, 0, 32'h9, 32'hB, 1'b0);
    checkOutput("t3_ptr_is_2", 64'(req_ready), 64'h4);

    // Same destination from req0 and req2: later grant wins.
    doReset();
    applyStimulus(3'b101, 5'd5, 0, 5'd5, 32'hA, 0, 32'hB, 1'b0);
    checkOutput("t4_ready0", 64'(req_ready), 64'h1);
    applyStimulus(3'b100, 0, 0, 5'd5, 0, 0, 32'hB, 1'b0);
    checkOutput("t4_ready2", 64'(req_ready), 64'h4);
    checkOutput("t4_WD3_first", 64'(WD3), 64'hA);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("t4_WD3_second", 64'(WD3), 64'hB);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput("t4_rf_r5", 64'(rf_dut[5]), 64'hB);

    // hold blocks grants; the in-flight write still lands.
    doReset();
    applyStimulus(3'b001, 5'd4, 0, 0, 32'h44, 0, 0, 1'b0);
    checkOutput("t5_ready0", 64'(req_ready), 64'h1);
    applyStimulus(3'b110, 0, 5'd6, 5'd12, 0, 32'h66, 32'hCC, 1'b1);
    checkOutput("t5_hold_ready", 64'(req_ready), 64'h0);
    checkOutput("t5_inflight_WE3", 64'(WE3), 64'd1);
    checkOutput("t5_inflight_AD3", 64'(AD3), 64'd4);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b110, 0, 5'd6, 5'd12, 0, 32'h66, 32'hCC, 1'b1);
      checkOutput("t5_hold_ready", 64'(req_ready), 64'h0);
      checkOutput("t5_hold_WE3", 64'(WE3), 64'd0);
    end
    applyStimulus(3'b110, 0, 5'd6, 5'd12, 0, 32'h66, 32'hCC, 1'b0);
    checkOutput("t5_release_ready1", 64'(req_ready), 64'h2);

    // Asynchronous reset while a write is in flight.
    doReset();
    applyStimulus(3'b001, 5'd7, 0, 0, 32'h77, 0, 0, 1'b0);
    checkOutput("t6_ready0", 64'(req_ready), 64'h1);
    applyStimulus(3'b110, 0, 5'd8, 5'd9, 0, 32'h88, 32'h99, 1'b1);
    checkOutput("t6_WE3_before", 64'(WE3), 64'd1);
    checkOutput("t6_AD3_before", 64'(AD3), 64'd7);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_WE3", 64'(WE3), 64'd0);
    checkOutput("t6_rst_AD3", 64'(AD3), 64'd0);
    checkOutput("t6_rst_ready", 64'(req_ready), 64'h0);
    checkOutput("t6_rst_pend", 64'(pend_mask), 64'h0000_0300);
    #1 rst_n = 1'b1;
    applyStimulus(3'b111, 5'd3, 5'd8, 5'd9, 32'h33, 32'h88, 32'h99, 1'b0);
    checkOutput("t6_restart_ready0", 64'(req_ready), 64'h1);

    // Randomized traffic obeying the requester rules.
    doReset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      xfer = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || xfer[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                            : AW'($urandom_range(0, 7));
          req_data[i*DW +: DW] = $urandom;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
